// File: rtl/spi_txn_arbiter_if.sv
// Signal bundle between the system-side requesters / SPI top level and the
// transaction arbiter.
//   req        requester levels (NREQ), held until ack
//   req_data   32-bit word per requester, requester k at [32k+31:32k]
//   req_ctrl   7-bit control per requester: [0] slave, [1] cpha, [2] cpol, [6:3] dvsr
//   ack        one-cycle completion pulse to the winning requester
//   rsp_data   received word, valid with ack
//   rsp_err    timeout flag, valid with ack
//   busy       arbiter occupied (grant through end of the idle gap)
//   spi_start  start pulse to the SPI master
//   spi_wdata  word handed to the SPI master
//   spi_ctrl   control word handed to the SPI master
//   spi_rdata  word captured by the SPI master
//   spi_done   per-slave done from the SPI top level
// Modport slave is the arbiter's view; modport master is the environment's view.
interface spi_txn_arbiter_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]      req;
  logic [32*NREQ-1:0]   req_data;
  logic [7*NREQ-1:0]    req_ctrl;
  logic [NREQ-1:0]      ack;
  logic [31:0]          rsp_data;
  logic                 rsp_err;
  logic                 busy;
  logic                 spi_start;
  logic [31:0]          spi_wdata;
  logic [6:0]           spi_ctrl;
  logic [31:0]          spi_rdata;
  logic [3:0]           spi_done;

  modport slave (
    input  req, req_data, req_ctrl, spi_rdata, spi_done,
    output ack, rsp_data, rsp_err, busy, spi_start, spi_wdata, spi_ctrl
  );

  modport master (
    output req, req_data, req_ctrl, spi_rdata, spi_done,
    input  ack, rsp_data, rsp_err, busy, spi_start, spi_wdata, spi_ctrl
  );
endinterface

// File: rtl/spi_txn_arbiter.sv
// Round-robin arbiter sharing one SPI master among NREQ requesters. Latches the
// winner's word/control, pulses start, waits for a rising edge of the selected
// slave's done (or a timeout), returns the captured word with ack, then holds
// off for GAP idle cycles before the next arbitration.
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous, active-high
//   bus    spi_txn_arbiter_if.slave (request side and SPI side, see interface)
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_IDLE   | no transfer; arbitrate among req, latch winner's data/ctrl
// S_LAUNCH | data/ctrl stable at the SPI master; start registered here
// S_WAIT   | start visible; wait for done edge of selected slave or timeout
// S_DONE   | ack/rsp_data/rsp_err presented for one cycle; pointer advances
// S_GAP    | forced idle cycles before the next arbitration, busy held
module spi_txn_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 4096,
  parameter int GAP     = 2
) (
  input logic              clk,
  input logic              reset,
  spi_txn_arbiter_if.slave bus
);
  localparam int PW       = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int MAXC     = (TIMEOUT > GAP) ? TIMEOUT : GAP;
  localparam int CW       = $clog2(MAXC + 1);
  localparam int GAP_LAST = (GAP > 0) ? GAP - 1 : 0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_DONE,
    S_GAP
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   ptr_q, win_q, gnt_idx, cand;
  logic            gnt_valid;
  logic [CW-1:0]   cnt_q;
  logic            done_q, done_sel, complete, expire;
  logic [NREQ-1:0] ack_q;
  logic [31:0]     rsp_data_q, wdata_q;
  logic            rsp_err_q, busy_q, start_q;
  logic [6:0]      ctrl_q;

  // Scan from the highest offset down so the lowest offset from the pointer
  // is the last (winning) assignment.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      cand = PW'((int'(ptr_q) + i) % NREQ);
      if (bus.req[cand]) begin
        gnt_valid = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  // Only the latched slave index matters; other done bits never reach here.
  assign done_sel = bus.spi_done[{1'b0, ctrl_q[0]}];
  assign complete = (state_q == S_WAIT) && done_sel && !done_q;
  assign expire   = (state_q == S_WAIT) && !complete && (cnt_q == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (gnt_valid) state_d = S_LAUNCH;
      S_LAUNCH: state_d = S_WAIT;
      S_WAIT:   if (complete || expire) state_d = S_DONE;
      S_DONE:   state_d = (GAP == 0) ? S_IDLE : S_GAP;
      S_GAP:    if (cnt_q == CW'(GAP_LAST)) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q      <= '0;
      win_q      <= '0;
      cnt_q      <= '0;
      done_q     <= 1'b0;
      ack_q      <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
      busy_q     <= 1'b0;
      start_q    <= 1'b0;
      wdata_q    <= '0;
      ctrl_q     <= '0;
    end else begin
      // done_q runs every cycle so a done already high during launch is seen
      // as "previous = 1" on the first wait cycle and cannot complete.
      done_q  <= done_sel;
      start_q <= (state_q == S_LAUNCH);
      busy_q  <= (state_d != S_IDLE);
      ack_q   <= '0;

      // One counter serves both the wait timeout and the gap; it restarts on
      // every state change.
      if ((state_q == state_d) && ((state_q == S_WAIT) || (state_q == S_GAP)))
        cnt_q <= cnt_q + CW'(1);
      else
        cnt_q <= '0;

      if ((state_q == S_IDLE) && gnt_valid) begin
        wdata_q <= bus.req_data[32*int'(gnt_idx) +: 32];
        ctrl_q  <= bus.req_ctrl[7*int'(gnt_idx) +: 7];
        win_q   <= gnt_idx;
      end

      if (complete || expire) begin
        ack_q[win_q] <= 1'b1;
        rsp_data_q   <= complete ? bus.spi_rdata : 32'h0;
        rsp_err_q    <= expire;
      end

      if (state_q == S_DONE)
        ptr_q <= (int'(win_q) == NREQ - 1) ? '0 : win_q + PW'(1);
    end
  end

  assign bus.ack       = ack_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.busy      = busy_q;
  assign bus.spi_start = start_q;
  assign bus.spi_wdata = wdata_q;
  assign bus.spi_ctrl  = ctrl_q;
endmodule

// File: tb/tb_spi_txn_arbiter.sv
// Directed bench for spi_txn_arbiter. dut_a: TIMEOUT=64, GAP=2. dut_b: TIMEOUT=16,
// GAP=0 for the timeout and zero-gap cases.
module tb_spi_txn_arbiter;
  logic clk = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  spi_txn_arbiter_if #(.NREQ(4)) bus_a ();
  spi_txn_arbiter_if #(.NREQ(4)) bus_b ();

  spi_txn_arbiter #(.NREQ(4), .TIMEOUT(64), .GAP(2)) dut_a (
    .clk(clk), .reset(reset), .bus(bus_a.slave)
  );
  spi_txn_arbiter #(.NREQ(4), .TIMEOUT(16), .GAP(0)) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b.slave)
  );

  logic [31:0] dw [4];
  logic [6:0]  cw [4];
  int          ord [5];
  int          n;
  int          w;
  logic [3:0]  acc;

  task automatic step(input int k = 1);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_start(input bit use_b, input int max, output int cyc);
    cyc = 0;
    while (((use_b ? bus_b.spi_start : bus_a.spi_start) !== 1'b1) && (cyc < max)) begin
      step();
      cyc++;
    end
  endtask

  initial begin
    dw  = '{32'hC0DE_0000, 32'hC0DE_1111, 32'hC0DE_2222, 32'hC0DE_3333};
    cw  = '{7'h08, 7'h11, 7'h18, 7'h21};
    ord = '{0, 1, 2, 3, 0};
    reset = 1'b1;
    bus_a.req = '0; bus_a.req_data = '0; bus_a.req_ctrl = '0;
    bus_a.spi_rdata = '0; bus_a.spi_done = '0;
    bus_b.req = '0; bus_b.req_data = '0; bus_b.req_ctrl = '0;
    bus_b.spi_rdata = '0; bus_b.spi_done = '0;
    step(3);

    // reset values
    chk("rst_ack",      32'(bus_a.ack), 32'h0);
    chk("rst_rsp_data", bus_a.rsp_data, 32'h0);
    chk("rst_rsp_err",  32'(bus_a.rsp_err), 32'h0);
    chk("rst_busy",     32'(bus_a.busy), 32'h0);
    chk("rst_start",    32'(bus_a.spi_start), 32'h0);
    chk("rst_wdata",    bus_a.spi_wdata, 32'h0);
    chk("rst_ctrl",     32'(bus_a.spi_ctrl), 32'h0);
    reset = 1'b0;
    step();

    // single transfer, done[0] 40 cycles after start
    bus_a.req_data[31:0] = 32'hA5A5_0F0F;
    bus_a.req_ctrl[6:0]  = 7'b0001_0_1_0;
    bus_a.req[0] = 1'b1;
    wait_start(1'b0, 20, n);
    chk("t1_start_latency", 32'(n), 32'd2);
    chk("t1_wdata", bus_a.spi_wdata, 32'hA5A5_0F0F);
    chk("t1_ctrl",  32'(bus_a.spi_ctrl), 32'h0A);
    chk("t1_busy",  32'(bus_a.busy), 32'h1);
    step();
    chk("t1_start_one_cycle", 32'(bus_a.spi_start), 32'h0);
    bus_a.req[0] = 1'b0;
    step(39);
    chk("t1_no_early_ack", 32'(bus_a.ack), 32'h0);
    bus_a.spi_rdata = 32'h1234_5678;
    bus_a.spi_done  = 4'b0001;
    step();
    chk("t1_ack",      32'(bus_a.ack), 32'h1);
    chk("t1_rsp_data", bus_a.rsp_data, 32'h1234_5678);
    chk("t1_rsp_err",  32'(bus_a.rsp_err), 32'h0);
    bus_a.spi_done = 4'b0000;
    step();
    chk("t1_ack_pulse", 32'(bus_a.ack), 32'h0);
    step();
    chk("t1_busy_in_gap", 32'(bus_a.busy), 32'h1);
    step();
    chk("t1_busy_falls", 32'(bus_a.busy), 32'h0);

    // fairness: all four requesting, pointer reset to 0
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      bus_a.req_data[32*k +: 32] = dw[k];
      bus_a.req_ctrl[7*k +: 7]   = cw[k];
    end
    bus_a.req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      w = ord[i];
      wait_start(1'b0, 20, n);
      chk($sformatf("t2_latency_%0d", i), 32'(n), (i == 0) ? 32'd2 : 32'd5);
      chk($sformatf("t2_wdata_%0d", i), bus_a.spi_wdata, dw[w]);
      chk($sformatf("t2_ctrl_%0d", i), 32'(bus_a.spi_ctrl), 32'(cw[w]));
      step(2);
      bus_a.spi_rdata = 32'h5A00_0000 | 32'(i);
      bus_a.spi_done  = 4'(1 << (w & 1));
      step();
      chk($sformatf("t2_ack_%0d", i), 32'(bus_a.ack), 32'(1 << w));
      chk($sformatf("t2_rsp_%0d", i), bus_a.rsp_data, 32'h5A00_0000 | 32'(i));
      chk($sformatf("t2_err_%0d", i), 32'(bus_a.rsp_err), 32'h0);
      bus_a.spi_done = 4'b0000;
      if (i == 4) bus_a.req = 4'b0000;
    end
    step(3);

    // stale done on slave 1 held high before launch
    bus_a.spi_done = 4'b0010;
    bus_a.req = 4'b0010;
    wait_start(1'b0, 20, n);
    chk("t4_latency", 32'(n), 32'd2);
    acc = '0;
    repeat (5) begin
      step();
      acc |= bus_a.ack;
    end
    bus_a.spi_done = 4'b0000;
    step(2);
    acc |= bus_a.ack;
    chk("t4_stale_ignored", 32'(acc), 32'h0);
    bus_a.spi_rdata = 32'h0BAD_F00D;
    bus_a.spi_done  = 4'b0010;
    step();
    chk("t4_ack", 32'(bus_a.ack), 32'h2);
    chk("t4_rsp", bus_a.rsp_data, 32'h0BAD_F00D);
    bus_a.spi_done = 4'b0000;
    bus_a.req = 4'b0000;
    step(3);

    // done on the wrong slave is ignored
    bus_a.req = 4'b0100;
    wait_start(1'b0, 20, n);
    chk("t5_latency", 32'(n), 32'd2);
    bus_a.spi_rdata = 32'hFFFF_FFFF;
    bus_a.spi_done  = 4'b0010;
    step();
    acc = bus_a.ack;
    bus_a.spi_done = 4'b0000;
    repeat (3) begin
      step();
      acc |= bus_a.ack;
    end
    chk("t5_wrong_slave_ignored", 32'(acc), 32'h0);
    bus_a.spi_rdata = 32'h5A5A_0202;
    bus_a.spi_done  = 4'b0001;
    step();
    chk("t5_ack", 32'(bus_a.ack), 32'h4);
    chk("t5_rsp", bus_a.rsp_data, 32'h5A5A_0202);
    bus_a.spi_done = 4'b0000;
    bus_a.req = 4'b0000;
    step(3);

    // timeout on dut_b (TIMEOUT=16, GAP=0)
    for (int k = 0; k < 4; k++) begin
      bus_b.req_data[32*k +: 32] = dw[k];
      bus_b.req_ctrl[7*k +: 7]   = 7'h08;
    end
    bus_b.spi_rdata = 32'hDEAD_BEEF;
    bus_b.req = 4'b0011;
    wait_start(1'b1, 20, n);
    chk("t3_latency", 32'(n), 32'd2);
    step(15);
    chk("t3_no_early_ack", 32'(bus_b.ack), 32'h0);
    step();
    chk("t3_ack", 32'(bus_b.ack), 32'h1);
    chk("t3_err", 32'(bus_b.rsp_err), 32'h1);
    chk("t3_rsp_zero", bus_b.rsp_data, 32'h0);
    bus_b.req = 4'b0010;
    step();
    chk("t3_busy_nogap", 32'(bus_b.busy), 32'h0);
    wait_start(1'b1, 20, n);
    chk("t3_next_latency", 32'(n), 32'd2);
    chk("t3_next_wdata", bus_b.spi_wdata, dw[1]);
    step();
    bus_b.spi_done = 4'b0001;
    step();
    chk("t3_next_ack", 32'(bus_b.ack), 32'h2);
    chk("t3_next_err", 32'(bus_b.rsp_err), 32'h0);
    chk("t3_next_rsp", bus_b.rsp_data, 32'hDEAD_BEEF);
    bus_b.spi_done = 4'b0000;
    bus_b.req = 4'b0000;
    step(2);

    // reset during WAIT
    bus_a.req = 4'b1000;
    wait_start(1'b0, 20, n);
    chk("t6_latency", 32'(n), 32'd2);
    step(3);
    reset = 1'b1;
    #1;
    chk("t6_busy",  32'(bus_a.busy), 32'h0);
    chk("t6_wdata", bus_a.spi_wdata, 32'h0);
    chk("t6_ctrl",  32'(bus_a.spi_ctrl), 32'h0);
    chk("t6_rsp",   bus_a.rsp_data, 32'h0);
    chk("t6_start", 32'(bus_a.spi_start), 32'h0);
    step(2);
    chk("t6_no_ack", 32'(bus_a.ack), 32'h0);
    reset = 1'b0;
    wait_start(1'b0, 20, n);
    chk("t6_again_latency", 32'(n), 32'd2);
    chk("t6_again_wdata", bus_a.spi_wdata, dw[3]);
    step();
    bus_a.spi_rdata = 32'h7777_0003;
    bus_a.spi_done  = 4'b0010;
    step();
    chk("t6_again_ack", 32'(bus_a.ack), 32'h8);
    chk("t6_again_rsp", bus_a.rsp_data, 32'h7777_0003);
    bus_a.spi_done = 4'b0000;
    bus_a.req = 4'b0000;
    step(4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
